// File: rtl/dmem_io_pkg.sv
// rtl/dmem_io_pkg.sv - register offsets, event bit indices and seven-segment patterns for the I/O responder
package dmem_io_pkg;

    localparam logic [2:0] OFF_DISP  = 3'd0;
    localparam logic [2:0] OFF_SW    = 3'd1;
    localparam logic [2:0] OFF_EVT   = 3'd2;
    localparam logic [2:0] OFF_TIMER = 3'd3;

    localparam int EVT_SW0_RISE = 0;
    localparam int EVT_SW1_RISE = 1;
    localparam int EVT_SW0_FALL = 2;
    localparam int EVT_SW1_FALL = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns, digit 0 in the least significant slot
    localparam logic [16*7-1:0] SEG_PATTERNS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [4:0] disp);
        if (disp[4])
            return SEG_BLANK;
        return SEG_PATTERNS[7*int'(disp[3:0]) +: 7];
    endfunction

endpackage

// File: rtl/dmem_io_responder_if.sv
// rtl/dmem_io_responder_if.sv - data-memory bus as seen by the processor and by the I/O responder
interface dmem_io_responder_if;

    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic        io_hit;

    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread,
        input  dmemrdata, io_hit
    );

    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread,
        output dmemrdata, io_hit
    );

endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchronizer plus stability counter with rise/fall pulses
module switch_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall
);

    logic        sync1;
    logic        sync2;
    logic [15:0] cnt;
    logic        differ;
    logic        flip;

    assign differ = sync2 != state;
    assign flip   = differ && (cnt == DEBOUNCE_CYCLES - 16'd1);
    // Pulses coincide with the edge that flips state, so the event register sets on that same edge
    assign rise   = flip & sync2;
    assign fall   = flip & ~sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= 16'd0;
            state <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (flip) begin
                state <= ~state;
                cnt   <= 16'd0;
            end else if (differ) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= 16'd0;
            end
        end
    end

endmodule

// File: rtl/dmem_io_responder.sv
// rtl/dmem_io_responder.sv - memory-mapped I/O window: display, debounced switches, sticky events
// Optional free-running timer at offset 3 when DMEM_IO_TIMER_EN is defined.
module dmem_io_responder
    import dmem_io_pkg::*;
#(
    parameter logic [15:0] IO_BASE         = 16'hFFF0,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4
) (
    input  logic                clock,
    input  logic                reset,
    dmem_io_responder_if.slave  bus,
    input  logic                io_sw0,
    input  logic                io_sw1,
    output logic [6:0]          io_display
);

    logic [2:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic [4:0]  disp_q;
    logic [3:0]  evt_q;
    logic [3:0]  evt_set;
    logic        evt_clr;
    logic [1:0]  sw_state;
    logic [1:0]  sw_rise;
    logic [1:0]  sw_fall;
    logic [15:0] timer_val;
    logic [15:0] rdata_sel;
    logic        unused_bits;

    assign offset      = bus.dmemaddr[3:1];
    assign bus.io_hit  = bus.dmemaddr[15:4] == IO_BASE[15:4];
    assign wr_en       = bus.io_hit & bus.dmemwrite;
    assign rd_en       = bus.io_hit & bus.dmemread;
    assign unused_bits = &{1'b0, bus.dmemaddr[0], bus.dmemwdata[15:5]};

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
        .clock (clock),
        .reset (reset),
        .raw   (io_sw0),
        .state (sw_state[0]),
        .rise  (sw_rise[0]),
        .fall  (sw_fall[0])
    );

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .clock (clock),
        .reset (reset),
        .raw   (io_sw1),
        .state (sw_state[1]),
        .rise  (sw_rise[1]),
        .fall  (sw_fall[1])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            disp_q <= 5'h10;
        else if (wr_en && offset == OFF_DISP)
            disp_q <= bus.dmemwdata[4:0];
    end

    always_comb begin
        evt_set = 4'h0;
        evt_set[EVT_SW0_RISE] = sw_rise[0];
        evt_set[EVT_SW1_RISE] = sw_rise[1];
        evt_set[EVT_SW0_FALL] = sw_fall[0];
        evt_set[EVT_SW1_FALL] = sw_fall[1];
    end

    assign evt_clr = rd_en && offset == OFF_EVT;

    // A new event on the clearing edge survives so it is never lost to a racing read
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            evt_q <= 4'h0;
        else
            evt_q <= (evt_clr ? 4'h0 : evt_q) | evt_set;
    end

`ifdef DMEM_IO_TIMER_EN
    logic [15:0] timer_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            timer_q <= 16'h0000;
        else if (wr_en && offset == OFF_TIMER)
            timer_q <= bus.dmemwdata;
        else
            timer_q <= timer_q + 16'd1;
    end

    assign timer_val = timer_q;
`else
    assign timer_val = 16'h0000;
`endif

    always_comb begin
        rdata_sel = 16'h0000;
        case (offset)
            OFF_DISP:  rdata_sel = {11'h000, disp_q};
            OFF_SW:    rdata_sel = {14'h0000, sw_state};
            OFF_EVT:   rdata_sel = {12'h000, evt_q};
            OFF_TIMER: rdata_sel = timer_val;
            default:   rdata_sel = 16'h0000;
        endcase
    end

    assign bus.dmemrdata = rd_en ? rdata_sel : 16'h0000;
    assign io_display    = seg_decode(disp_q);

endmodule

// File: doc/dmem_io_responder.md
Name: dmem_io_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus (dmemaddr/dmemwdata/dmemwrite/dmemread/dmemrdata).
- Sits beside the data RAM and answers I/O-window accesses. A top-level mux selects RAM or this block's rdata using io_hit.
- Owns the board I/O: two debounced slide switches, sticky switch-edge events, a 7-segment display register, and an optional free-running timer.

Parameters:
- IO_BASE, 16'hFFF0, base address of the 16-byte I/O window; low 4 bits must be zero.
- DEBOUNCE_CYCLES, 16'd4, consecutive stable synchronized samples before a switch state is accepted; must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmemaddr  in  16  byte address from processor.
- dmemwdata  in  16  write data.
- dmemwrite  in  1  write enable.
- dmemread  in  1  read enable.
- dmemrdata  out  16  read data; combinational.
- io_hit  out  1  high when dmemaddr[15:4]==IO_BASE[15:4]; combinational.
- io_sw0  in  1  raw slide switch 0; asynchronous.
- io_sw1  in  1  raw slide switch 1; asynchronous.
- io_display  out  7  segments g..a (bit6=g, bit0=a), active-low.

Behaviour:
- Register map. The offset is dmemaddr[3:1]; dmemaddr[0] is ignored.
  - 0 DISP (R/W): bits[3:0] hex digit, bit4 blank. Other bits read 0.
  - 1 SW (RO): bit0 sw0 debounced, bit1 sw1 debounced.
  - 2 EVT (read-to-clear): bit0 sw0 rose, bit1 sw1 rose, bit2 sw0 fell, bit3 sw1 fell.
  - 3 TIMER: see Optional Feature.
  - 4-7: reserved; read 0, writes ignored.
- Read path:
  - dmemrdata equals the selected register when io_hit && dmemread.
  - dmemrdata is 16'h0000 otherwise.
  - Read latency is zero cycles, which matches single-cycle MEM-stage access.
- Write path: when io_hit && dmemwrite, the addressed register updates at the next rising clock edge. A simultaneous read and write to the same register returns the old value.
- Reset values:
  - DISP = 5'h10 (blank), so io_display = 7'h7F.
  - Debounced switch states = 0; EVT = 0; TIMER = 0.
  - Synchronizer flops = 0; debounce counters = 0.
- Debounce, per switch:
  - Two-flop synchronizer, then a counter.
  - If the synchronized value differs from the debounced state, the counter increments. Otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while a difference persists, the debounced state flips and the counter clears. The flip therefore comes DEBOUNCE_CYCLES+2 edges after a clean raw change.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized samples never flips the state.
- EVT:
  - A debounced flip sets the matching rise or fall bit.
  - A read of EVT (io_hit && dmemread && offset 2) clears all bits at the next edge.
  - If a set and a clear occur on the same edge, the set wins for that bit.
  - Writes to EVT are ignored.
- Display decode:
  - Blank=1 gives 7'h7F.
  - Otherwise hex 0-F gives standard active-low patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - io_display is registered from DISP through a combinational decoder. It changes in the cycle after the DISP write edge.
- Reset mid-operation forces all state to its reset value immediately and asynchronously, including in-progress debounce counts and pending events.

Optional Feature:
- Macro: DMEM_IO_TIMER_EN.
- Defined:
  - TIMER is a 16-bit up-counter, +1 every cycle, wrapping FFFF to 0000.
  - A read returns the current value.
  - Any write loads dmemwdata. The written value appears on the next read and counting resumes from it.
- Undefined: offset 3 reads 0, writes are ignored, and no counter flops exist.

Decomposition:
- Package dmem_io_pkg:
  - Offset constants OFF_DISP=3'd0, OFF_SW=3'd1, OFF_EVT=3'd2, OFF_TIMER=3'd3.
  - EVT bit indices.
  - The 16-entry seven-segment pattern constant.
  - The blank pattern 7'h7F.
- One sub-module, switch_debounce: synchronizer, counter, and stable output with rise/fall pulses. It is instantiated twice.
- Decode, register file and EVT logic stay in the top level.

Test Plan:
- Reset sequence:
  - Stimulus: assert reset for 2 cycles with the switches at 0.
  - Required: io_display=7'h7F; reads of addresses FFF0/FFF2/FFF4 return 0010/0000/0000; io_hit=1 for FFF0 and 0 for 0x0010.
- Display write:
  - Stimulus: write 16'h0007 to FFF0, then 16'h000A.
  - Required: io_display=7'h78 one cycle after the first write and 7'h08 after the second; reading FFF0 returns 000A.
  - Follow-up: write 16'h0013; required io_display=7'h7F.
- Debounce:
  - Stimulus: raise io_sw1 for 2 cycles, then drop it.
  - Required: SW stays 0000 and EVT stays 0000.
  - Stimulus: raise io_sw1 and hold it for 10 cycles.
  - Required: SW=0002 exactly 6 edges after the raw rise; EVT=0002.
- Read-to-clear race:
  - Stimulus: read FFF4 in the same cycle that sw0 debounces high.
  - Required: the read returns the prior EVT value, and EVT=0001 afterwards.
  - Follow-up: a later read returns 0001 and clears EVT to 0000.
- Timer (DMEM_IO_TIMER_EN defined):
  - Stimulus: write FFFE to FFF6, then read over the next cycles.
  - Required: reads return FFFE, FFFF, 0000, ...
  - With the macro undefined: FFF6 reads 0000 always.
- Asynchronous reset mid-operation:
  - Stimulus: DISP=3 with sw0 partway through debouncing; pulse reset between clock edges.
  - Required: io_display=7'h7F immediately; a held sw0 needs a full DEBOUNCE_CYCLES+2 edges after reset release before SW=0001.
